// File: rtl/conf_int_add__operand_stage.sv
// Operand staging for the configurable-precision adder: 2-entry FIFO of masked operand bundles.
// Latency 1 cycle; in_ready drops when full or while a precision change drains/applies.
module conf_int_add__operand_stage #(
  parameter int DATA_PATH_BITWIDTH = 16,
  parameter int CONF_SELECT__C_B   = 4,
  parameter int TRUNC_STEP         = 4,
  parameter int MAX_LEVEL          = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0] in_a,
  input  logic [DATA_PATH_BITWIDTH-1:0] in_b,
  input  logic [DATA_PATH_BITWIDTH-1:0] in_d,
  input  logic [DATA_PATH_BITWIDTH-1:0] in_e,
  input  logic                          cfg_valid,
  input  logic [CONF_SELECT__C_B-1:0]   cfg_sel,
  output logic                          cfg_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_PATH_BITWIDTH-1:0] out_a,
  output logic [DATA_PATH_BITWIDTH-1:0] out_b,
  output logic [DATA_PATH_BITWIDTH-1:0] out_d,
  output logic [DATA_PATH_BITWIDTH-1:0] out_e,
  output logic [CONF_SELECT__C_B-1:0]   out_conf_select,
  output logic                          busy
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_PATH_BITWIDTH-1:0] a;
    logic [DATA_PATH_BITWIDTH-1:0] b;
    logic [DATA_PATH_BITWIDTH-1:0] d;
    logic [DATA_PATH_BITWIDTH-1:0] e;
    logic [CONF_SELECT__C_B-1:0]   tag;
  } entry_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [CONF_SELECT__C_B-1:0]   r_conf_reg;
  logic [CONF_SELECT__C_B-1:0]   r_pending_cfg;
  logic [1:0]                    r_count;
  logic [1:0]                    w_count_nxt;
  entry_t                        r_q0;
  entry_t                        r_q1;
  entry_t                        w_new;
  logic                          w_push;
  logic                          w_pop;
  logic [DATA_PATH_BITWIDTH-1:0] w_mask;
  int                            w_level;
  int                            w_trunc;

  // Codes above MAX_LEVEL fall back to full precision; truncation saturates at the operand width.
  always_comb begin
    w_level = 0;
    if (int'(r_conf_reg) <= MAX_LEVEL) w_level = int'(r_conf_reg);
    w_trunc = w_level * TRUNC_STEP;
    if (w_trunc > DATA_PATH_BITWIDTH) w_trunc = DATA_PATH_BITWIDTH;
    for (int i = 0; i < DATA_PATH_BITWIDTH; i++) w_mask[i] = (i >= w_trunc);
  end

  assign w_new.a   = in_a & w_mask;
  assign w_new.b   = in_b & w_mask;
  assign w_new.d   = in_d & w_mask;
  assign w_new.e   = in_e & w_mask;
  assign w_new.tag = r_conf_reg;

  assign in_ready  = (r_state == RUN) && !cfg_valid && (r_count < 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign cfg_ready = (r_state == UPDATE);
  assign busy      = (r_state != RUN) || (r_count != 2'd0);

  assign out_a           = r_q0.a;
  assign out_b           = r_q0.b;
  assign out_d           = r_q0.d;
  assign out_e           = r_q0.e;
  assign out_conf_select = r_q0.tag;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) w_count_nxt = r_count + 2'd1;
    else if (!w_push && w_pop) w_count_nxt = r_count - 2'd1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (cfg_valid) w_state_nxt = (r_count == 2'd0) ? UPDATE : DRAIN;
      DRAIN:   if (w_count_nxt == 2'd0) w_state_nxt = UPDATE;
      UPDATE:  w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_conf_reg    <= '0;
      r_pending_cfg <= '0;
      r_count       <= 2'd0;
      r_q0          <= '0;
      r_q1          <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (r_state == RUN && cfg_valid) r_pending_cfg <= cfg_sel;
      if (r_state == UPDATE) r_conf_reg <= r_pending_cfg;
      // Head always lives in r_q0 so the outputs come straight from a register.
      if (w_pop) begin
        if (r_count == 2'd2) r_q0 <= r_q1;
        else if (w_push) r_q0 <= w_new;
      end else if (w_push) begin
        if (r_count == 2'd0) r_q0 <= w_new;
        else r_q1 <= w_new;
      end
    end
  end

endmodule

// File: tb/tb_conf_int_add__operand_stage.sv
// Directed bench for the operand staging stage: masking, FIFO ordering, and precision-change serialization.
module tb_conf_int_add__operand_stage;
  localparam int W = 16;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b, in_d, in_e;
  logic         cfg_valid;
  logic [C-1:0] cfg_sel;
  logic         cfg_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_a, out_b, out_d, out_e;
  logic [C-1:0] out_conf_select;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  conf_int_add__operand_stage #(
    .DATA_PATH_BITWIDTH(W), .CONF_SELECT__C_B(C), .TRUNC_STEP(4), .MAX_LEVEL(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_d(in_d), .in_e(in_e),
    .cfg_valid(cfg_valid), .cfg_sel(cfg_sel), .cfg_ready(cfg_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_d(out_d), .out_e(out_e),
    .out_conf_select(out_conf_select), .busy(busy)
  );

  // Request a configuration and drop cfg_valid on the cfg_ready cycle; bounded wait.
  task automatic do_cfg(input logic [C-1:0] sel);
    bit seen = 0;
    cfg_valid = 1'b1;
    cfg_sel   = sel;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cfg_ready === 1'b1) begin
        seen = 1;
        break;
      end
    end
    cfg_valid = 1'b0;
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL cfg_handshake sel=%0d: cfg_ready never seen, required 1 within 20 cycles", sel);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_d = '0; in_e = '0;
    cfg_valid = 1'b0; cfg_sel = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (cfg_ready !== 1'b0) begin n_errors++; $display("FAIL reset_cfg_ready got=%b exp=0", cfg_ready); end
    n_checks++; if (out_a !== 16'h0 || out_e !== 16'h0) begin n_errors++; $display("FAIL reset_out_data got=%h/%h exp=0/0", out_a, out_e); end
    n_checks++; if (out_conf_select !== 4'd0) begin n_errors++; $display("FAIL reset_conf got=%0d exp=0", out_conf_select); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic;
    in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h00FF; in_d = 16'hABCD; in_e = 16'h0001;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL basic_out_valid got=%b exp=1", out_valid); end
    n_checks++; if ({out_a, out_b, out_d, out_e} !== {16'h1234, 16'h00FF, 16'hABCD, 16'h0001}) begin
      n_errors++; $display("FAIL basic_data got=%h %h %h %h exp=1234 00ff abcd 0001", out_a, out_b, out_d, out_e); end
    n_checks++; if (out_conf_select !== 4'd0) begin n_errors++; $display("FAIL basic_conf got=%0d exp=0", out_conf_select); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL basic_pop got valid=%b busy=%b exp 0 0", out_valid, busy); end
  endtask

  task automatic test_cfg_empty;
    cfg_valid = 1'b1; cfg_sel = 4'd2;
    @(negedge clk);
    n_checks++; if (cfg_ready !== 1'b1) begin n_errors++; $display("FAIL cfg_empty_pulse got=%b exp=1", cfg_ready); end
    n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_errors++; $display("FAIL cfg_empty_update got busy=%b in_ready=%b exp 1 0", busy, in_ready); end
    cfg_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (cfg_ready !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL cfg_empty_after got cfg_ready=%b busy=%b exp 0 0", cfg_ready, busy); end
    in_valid = 1'b1; in_a = 16'h1234; in_b = 16'hFFFF; in_d = 16'h00FF; in_e = 16'h0100;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if ({out_a, out_b, out_d, out_e} !== {16'h1200, 16'hFF00, 16'h0000, 16'h0100}) begin
      n_errors++; $display("FAIL cfg2_mask got=%h %h %h %h exp=1200 ff00 0000 0100", out_a, out_b, out_d, out_e); end
    n_checks++; if (out_conf_select !== 4'd2) begin n_errors++; $display("FAIL cfg2_conf got=%0d exp=2", out_conf_select); end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_over_max;
    do_cfg(4'd5);
    in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0F0F;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (out_a !== 16'hFFFF || out_b !== 16'h0F0F) begin n_errors++; $display("FAIL over_max_mask got=%h %h exp=ffff 0f0f", out_a, out_b); end
    n_checks++; if (out_conf_select !== 4'd5) begin n_errors++; $display("FAIL over_max_conf got=%0d exp=5", out_conf_select); end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    do_cfg(4'd0);
  endtask

  task automatic test_full;
    in_b = '0; in_d = '0; in_e = '0;
    in_valid = 1'b1; in_a = 16'h0001;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL full_rdy0 got=%b exp=1", in_ready); end
    @(negedge clk);
    in_a = 16'h0002;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL full_rdy1 got=%b exp=1", in_ready); end
    @(negedge clk);
    in_a = 16'h0003;
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL full_rdy2 got=%b exp=0", in_ready); end
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0 || out_a !== 16'h0001) begin n_errors++; $display("FAIL full_hold got rdy=%b a=%h exp 0 0001", in_ready, out_a); end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || out_a !== 16'h0002) begin n_errors++; $display("FAIL full_order got v=%b a=%h exp 1 0002", out_valid, out_a); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL full_empty got=%b exp=0 (third bundle must not be accepted)", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] vals [4] = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_a = vals[i];
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1 || out_a !== vals[i] || in_ready !== 1'b1) begin
        n_errors++; $display("FAIL b2b_%0d got v=%b a=%h rdy=%b exp 1 %h 1", i, out_valid, out_a, in_ready, vals[i]); end
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_drain;
    in_valid = 1'b1; in_a = 16'h00A1; @(negedge clk);
    in_a = 16'h00A2; @(negedge clk);
    in_valid = 1'b0;
    cfg_valid = 1'b1; cfg_sel = 4'd4;
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL drain_rdy_req got=%b exp=0", in_ready); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b1 || cfg_ready !== 1'b0 || in_ready !== 1'b0) begin
      n_errors++; $display("FAIL drain_state got busy=%b cfg_ready=%b rdy=%b exp 1 0 0", busy, cfg_ready, in_ready); end
    n_checks++; if (out_a !== 16'h00A1 || out_conf_select !== 4'd0) begin n_errors++; $display("FAIL drain_head0 got a=%h conf=%0d exp 00a1 0", out_a, out_conf_select); end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (out_a !== 16'h00A2 || out_conf_select !== 4'd0 || cfg_ready !== 1'b0) begin
      n_errors++; $display("FAIL drain_head1 got a=%h conf=%0d cfg_ready=%b exp 00a2 0 0", out_a, out_conf_select, cfg_ready); end
    @(negedge clk);
    n_checks++; if (cfg_ready !== 1'b1 || out_valid !== 1'b0) begin n_errors++; $display("FAIL drain_update got cfg_ready=%b v=%b exp 1 0", cfg_ready, out_valid); end
    cfg_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (cfg_ready !== 1'b0 || in_ready !== 1'b1) begin n_errors++; $display("FAIL drain_run got cfg_ready=%b rdy=%b exp 0 1", cfg_ready, in_ready); end
    in_valid = 1'b1; in_a = 16'hFFFF;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (out_a !== 16'h0000 || out_conf_select !== 4'd4) begin n_errors++; $display("FAIL cfg4_mask got a=%h conf=%0d exp 0000 4", out_a, out_conf_select); end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    do_cfg(4'd0);
  endtask

  task automatic test_reset_mid_drain;
    in_valid = 1'b1; in_a = 16'h5555; @(negedge clk);
    in_valid = 1'b0;
    cfg_valid = 1'b1; cfg_sel = 4'd3;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1 || out_valid !== 1'b1) begin n_errors++; $display("FAIL mid_drain_pre got busy=%b v=%b exp 1 1", busy, out_valid); end
    rst = 1'b1; cfg_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b0) begin
      n_errors++; $display("FAIL mid_drain_rst got v=%b busy=%b cfg_ready=%b exp 0 0 0", out_valid, busy, cfg_ready); end
    @(negedge clk);
    n_checks++; if (cfg_ready !== 1'b0) begin n_errors++; $display("FAIL mid_drain_no_update got=%b exp=0", cfg_ready); end
    in_valid = 1'b1; in_a = 16'h5555;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (out_a !== 16'h5555 || out_conf_select !== 4'd0) begin
      n_errors++; $display("FAIL mid_drain_conf got a=%h conf=%0d exp 5555 0", out_a, out_conf_select); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cfg_empty();
    test_over_max();
    test_full();
    test_back_to_back();
    test_drain();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/conf_int_add__operand_stage.md
Name: conf_int_add__operand_stage

Overview:
- Upstream operand-staging stage for the configurable-precision integer adder: buffers operand bundles (a, b, d, e) in a 2-entry FIFO with valid/ready handshake.
- Zeroes the low-order bits of each operand according to the active precision configuration.
- Presents each bundle together with the conf_select value that produced it.
- Precision changes are serialized: a requested change drains the FIFO first, so no bundle is ever issued under mixed configurations.

Parameters:
- DATA_PATH_BITWIDTH, 16, width of each operand.
- CONF_SELECT__C_B, 4, width of the configuration word.
- TRUNC_STEP, 4, number of low bits zeroed per precision level.
- MAX_LEVEL, 4, highest legal precision level; codes above it mean full precision.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  stage can accept a bundle.
- in_a, in_b, in_d, in_e  in  DATA_PATH_BITWIDTH each  raw operands.
- cfg_valid  in  1  configuration change request.
- cfg_sel  in  CONF_SELECT__C_B  requested configuration.
- cfg_ready  out  1  one-cycle pulse: the configuration change has been applied.
- out_valid  out  1  head bundle valid toward the adder.
- out_ready  in  1  adder consumes the head bundle.
- out_a, out_b, out_d, out_e  out  DATA_PATH_BITWIDTH each  masked operands.
- out_conf_select  out  CONF_SELECT__C_B  configuration used for this bundle; drives the adder's conf_select.
- busy  out  1  state != RUN, or FIFO not empty.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - FIFO empty, count=0, state=RUN, conf_reg=0 (full precision), pending_cfg=0.
  - out_valid=0; out_a/b/d/e=0; out_conf_select=0; cfg_ready=0; busy=0.
  - A reset mid-drain or mid-update abandons the pending change and discards buffered bundles.
- Precision level: k = conf_reg when conf_reg <= MAX_LEVEL, otherwise k=0.
  - mask = all ones with the low min(k*TRUNC_STEP, DATA_PATH_BITWIDTH) bits cleared.
  - The mask is applied at enqueue, using the conf_reg value current in that cycle.
  - Bundles are stored already masked, together with a conf_reg tag.
- Push: occurs when in_valid && in_ready.
  - in_ready = (state==RUN) && !cfg_valid && (count<2).
  - A full FIFO deasserts in_ready even if out_ready=1; there is no combinational pass-through.
- Pop: occurs when out_valid && out_ready.
  - out_valid = (count!=0).
  - out_* are the head entry, driven from registers.
- Latency: a bundle accepted at edge N is visible with out_valid=1 after edge N; minimum 1 cycle.
- Simultaneous push and pop with count=1: count stays 1 and order is preserved.
- Pop with out_ready=0: the head and out_* are held stable.
- Throughput: 1 bundle/cycle at steady state with count<=1.
- Configuration FSM:
  - RUN:
    - When cfg_valid=1, capture pending_cfg<=cfg_sel.
    - If count==0 (and no push, guaranteed because in_ready=0), go to UPDATE; otherwise go to DRAIN.
  - DRAIN:
    - in_ready=0; pops continue.
    - When count reaches 0 (a pop at count==1 counts as reaching 0), go to UPDATE.
    - cfg_valid deasserting during DRAIN is ignored; pending_cfg is still applied.
  - UPDATE (1 cycle):
    - conf_reg<=pending_cfg; cfg_ready=1 (registered pulse, this cycle only); go to RUN.
    - in_ready=0 in this cycle.
- cfg_ready is asserted in UPDATE only. The requester holds cfg_valid until it sees cfg_ready and drops it in the following cycle.
- cfg_valid still high in the first RUN cycle after UPDATE is treated as a new request. The requester must drop cfg_valid on the cfg_ready cycle.
- Unchanged config (cfg_sel==conf_reg): the same drain and update sequence runs; no shortcut.
- Stall during DRAIN (out_ready=0): the FSM waits indefinitely, with no timeout.

Test Plan:
- Reset, then push a=16'h1234, b=16'h00FF, d=16'hABCD, e=16'h0001 with conf_reg=0 -> out_valid=1 one cycle later with unmasked values and out_conf_select=0.
- Request cfg_sel=2 while the FIFO is empty -> UPDATE next cycle, cfg_ready pulses once. Then push a=16'h1234 -> out_a=16'h1200 and out_conf_select=2.
- Set cfg_sel=5 (above MAX_LEVEL), then push a=16'hFFFF -> out_a=16'hFFFF (full precision) and out_conf_select=5.
- Hold out_ready=0 and push 3 bundles -> 2 are accepted, in_ready=0 while count=2. Release out_ready -> bundles emerge in order, one per cycle.
- With 2 bundles queued under cfg=0, request cfg_sel=4 -> in_ready=0 until both pop. Those 2 bundles emerge with out_conf_select=0; cfg_ready then pulses; the next bundle has out_a=0 and out_conf_select=4.
- Assert rst during DRAIN with count=1 -> the next cycle shows out_valid=0, busy=0, conf_reg=0, cfg_ready=0, and pending_cfg is not applied.
